regfile_writer: RTL
===================

# regfile_writer

Write-back arbiter that owns the single write port (rd, writedata, regwrite) of the MIPS register file. It merges single-cycle ALU results with results from the multi-cycle multiply/divide unit (MDU), buffering MDU results in a small FIFO, and exposes a pending-write query for the decode-stage hazard logic. Outputs are registered and feed the register file's write port directly; the register file commits them on the following rising clk edge.

## Interface
- DEPTH, 4: MDU result FIFO entries; power of two, ≥2.
- MAX_WAIT, 8: consecutive cycles a non-empty FIFO may lose to the ALU before a forced drain; ≥1.

- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- alu_valid  in  1  ALU result offered this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- stall_alu  out  1  ALU result not accepted this cycle; upstream holds alu_* stable.
- mdu_valid  in  1  MDU result offered.
- mdu_ready  out  1  FIFO can accept (= not full).
- mdu_rd  in  5  MDU destination register.
- mdu_data  in  32  MDU result.
- q_rs, q_rt  in  5 each  registers queried by decode.
- rs_busy, rt_busy  out  1 each  queried register has an uncommitted write here.
- rd  out  5  register file write address.
- writedata  out  32  register file write data.
- regwrite  out  1  register file write enable.

## Operation
- ALU transfer: alu_valid && !stall_alu. MDU transfer: mdu_valid && mdu_ready.
- Writes with destination 0 are accepted and discarded: no FIFO entry, no regwrite pulse.
- FIFO: circular, log2(DEPTH)-bit pointers wrapping modulo DEPTH, count 0..DEPTH. mdu_ready = (count != DEPTH), combinational. Push and pop in the same cycle allowed; count unchanged. Pop only when non-empty.
- Grant each cycle, one winner at most:
  - NORMAL state: accepted nonzero ALU write wins; otherwise FIFO head if non-empty; otherwise idle (regwrite=0 next cycle).
  - DRAIN state: stall_alu=1, FIFO head wins.
- Starvation counter wait_cnt: +1 each NORMAL cycle where FIFO non-empty and ALU wins; cleared on any FIFO pop or when FIFO empty.
- State machine, registered:
  - NORMAL -> DRAIN when the ALU wins while wait_cnt == MAX_WAIT-1 (increment reaches MAX_WAIT).
  - DRAIN -> NORMAL after exactly one cycle (one entry popped; wait_cnt cleared).
  - stall_alu is 1 only in DRAIN.
- Output register: winner's rd/data loaded with regwrite=1; no winner loads regwrite=0 and holds rd/writedata.
- Busy: rX_busy = (qX != 0) && (any valid FIFO entry has rd == qX, or regwrite && rd == qX). Combinational over registered state; same-cycle inputs are not included.

## Timing
- Reset (asynchronous): rd=0, writedata=0, regwrite=0, FIFO empty, wait_cnt=0, state NORMAL, stall_alu=0, mdu_ready=1, busy outputs 0. Reset mid-operation discards all buffered MDU results.
- ALU write: accepted at edge N; rd/writedata/regwrite valid after N; register file commits at edge N+1.
- MDU write: pushed at edge N; earliest on outputs after N+1 (no bypass); commit at N+2.
- FIFO full: mdu_ready=0 in that cycle; a pop that cycle does not re-enable mdu_ready until the next cycle.
- Worst-case MDU head wait: MAX_WAIT+1 cycles.

## Test plan
- Reset pulse mid-stream with FIFO holding 3 entries -> all outputs at reset values immediately, count=0, mdu_ready=1, no later regwrite for dropped entries.
- alu_valid, alu_rd=5, alu_data=0xDEADBEEF at edge N -> rd=5, writedata=0xDEADBEEF, regwrite=1 after N for one cycle; alu_rd=0 -> regwrite stays 0.
- MDU pushes rd=7 (0x11), rd=9 (0x22) with ALU idle -> regwrite pulses in order 7/0x11 then 9/0x22, first one cycle after first push; rt_busy=1 for q_rt=9 until its regwrite cycle ends.
- Same cycle ALU rd=3 and FIFO head rd=4 -> rd=3 first, rd=4 next cycle.
- DEPTH=4: 5 back-to-back MDU pushes with ALU saturating -> mdu_ready=0 after 4th push, 5th held.
- MAX_WAIT=8, ALU valid every cycle, one FIFO entry -> 8 ALU writes, then one cycle stall_alu=1 with MDU write, held ALU result follows next cycle.

Source files
------------

// File: rtl/regfile_writer.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writer
// Brief    : Register-file write-port arbiter merging ALU results with
//            FIFO-buffered MDU results, with starvation drain and busy query.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_writer #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        stall_alu,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    input  logic [4:0]  q_rs,
    input  logic [4:0]  q_rt,
    output logic        rs_busy,
    output logic        rt_busy,
    output logic [4:0]  rd,
    output logic [31:0] writedata,
    output logic        regwrite
);

    localparam int c_ptr_w  = $clog2(DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;
    localparam int c_wait_w = $clog2(MAX_WAIT + 1);

    localparam logic [c_cnt_w-1:0]  c_full      = c_cnt_w'(DEPTH);
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(MAX_WAIT - 1);

    localparam logic [0:0] c_st_normal = 1'b0;
    localparam logic [0:0] c_st_drain  = 1'b1;

    logic [4:0]          r_fifo_rd   [DEPTH];
    logic [31:0]         r_fifo_data [DEPTH];
    logic [DEPTH-1:0]    r_fifo_vld;
    logic [c_ptr_w-1:0]  r_wptr;
    logic [c_ptr_w-1:0]  r_rptr;
    logic [c_cnt_w-1:0]  r_count;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic [0:0]          r_state;

    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_alu_win;
    logic                w_starve;
    logic                w_win;
    logic [4:0]          w_win_rd;
    logic [31:0]         w_win_data;
    logic [DEPTH-1:0]    w_rs_match;
    logic [DEPTH-1:0]    w_rt_match;

    assign w_empty   = (r_count == '0);
    assign mdu_ready = (r_count != c_full);
    assign stall_alu = (r_state == c_st_drain);

    // Destination-0 MDU results complete the handshake but never occupy a slot.
    assign w_push = mdu_valid && mdu_ready && (mdu_rd != 5'd0);

    always_comb begin
        w_alu_win = 1'b0;
        w_pop     = 1'b0;
        if (r_state == c_st_normal) begin
            if (alu_valid && (alu_rd != 5'd0)) begin
                w_alu_win = 1'b1;
            end else if (!w_empty) begin
                w_pop = 1'b1;
            end
        end else begin
            w_pop = !w_empty;
        end
    end

    assign w_starve   = (r_state == c_st_normal) && w_alu_win && !w_empty;
    assign w_win      = w_alu_win || w_pop;
    assign w_win_rd   = w_alu_win ? alu_rd   : r_fifo_rd[r_rptr];
    assign w_win_data = w_alu_win ? alu_data : r_fifo_data[r_rptr];

    // Payload storage needs no reset; occupancy is tracked by r_fifo_vld.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wptr]   <= mdu_rd;
            r_fifo_data[r_wptr] <= mdu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_fifo_vld <= '0;
        end else begin
            if (w_push) begin
                r_wptr             <= r_wptr + 1'b1;
                r_fifo_vld[r_wptr] <= 1'b1;
            end
            if (w_pop) begin
                r_rptr             <= r_rptr + 1'b1;
                r_fifo_vld[r_rptr] <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_state    <= c_st_normal;
        end else begin
            if (w_empty || w_pop) begin
                r_wait_cnt <= '0;
            end else if (w_starve) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            case (r_state)
                c_st_normal: begin
                    if (w_starve && (r_wait_cnt == c_wait_last)) begin
                        r_state <= c_st_drain;
                    end
                end
                c_st_drain: begin
                    r_state <= c_st_normal;
                end
                default: begin
                    r_state <= c_st_normal;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd        <= 5'd0;
            writedata <= 32'd0;
            regwrite  <= 1'b0;
        end else begin
            regwrite <= w_win;
            if (w_win) begin
                rd        <= w_win_rd;
                writedata <= w_win_data;
            end
        end
    end

    // Busy covers both buffered entries and the write sitting on the output port.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            assign w_rs_match[gi] = r_fifo_vld[gi] && (r_fifo_rd[gi] == q_rs);
            assign w_rt_match[gi] = r_fifo_vld[gi] && (r_fifo_rd[gi] == q_rt);
        end
    endgenerate

    assign rs_busy = (q_rs != 5'd0) && ((|w_rs_match) || (regwrite && (rd == q_rs)));
    assign rt_busy = (q_rt != 5'd0) && ((|w_rt_match) || (regwrite && (rd == q_rt)));

endmodule
`default_nettype wire
